// File: rtl/locked_pkg.sv
// Shared types and default lock constants for the locked pipelined adder.
package locked_pkg;

   typedef enum logic [1:0] {
      KEY_IDLE,
      KEY_LOAD,
      KEY_ARMED
   } key_state_e;

   localparam logic [7:0] DEF_PROT_PATTERN = 8'h01;
   localparam logic [4:0] DEF_FLIP_MASK    = 5'h01;

endpackage

// File: rtl/locked_pipe_adder_if.sv
// Operand/result handshake and serial key provisioning bundle for locked_pipe_adder.
interface locked_pipe_adder_if #(
   parameter int unsigned W      = 4,
   parameter int unsigned OUT_CH = 2
);
   logic                       key_bit;
   logic                       key_valid;
   logic                       key_loaded;
   logic                       in_valid;
   logic                       in_ready;
   logic [2*W-1:0]             inputs;
   logic                       out_valid;
   logic                       out_ready;
   logic [OUT_CH*(W+1)-1:0]    out;

   modport master (
      output key_bit, key_valid, in_valid, inputs, out_ready,
      input  key_loaded, in_ready, out_valid, out
   );

   modport slave (
      input  key_bit, key_valid, in_valid, inputs, out_ready,
      output key_loaded, in_ready, out_valid, out
   );
endinterface

// File: rtl/lock_key_loader.sv
// Serial LSB-first key capture FSM. With LOCK_KEY_OTP_EN defined the armed key is
// one-time programmable until reset; otherwise key_valid while armed restarts loading.
module lock_key_loader
   import locked_pkg::*;
#(
   parameter int unsigned KW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_key_bit,
   input  logic          i_key_valid,
   output logic [KW-1:0] o_key,
   output logic          o_key_loaded,
   output logic          o_flush
);
   localparam int unsigned      CW       = (KW > 1) ? $clog2(KW) : 1;
   localparam logic [CW-1:0]    LAST_IDX = CW'(KW - 1);

   key_state_e    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [KW-1:0] r_key, w_key_nxt;
   logic          r_loaded, w_loaded_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= KEY_IDLE;
         r_cnt    <= '0;
         r_key    <= '0;
         r_loaded <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_key    <= w_key_nxt;
         r_loaded <= w_loaded_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_key_nxt    = r_key;
      w_loaded_nxt = r_loaded;
      o_flush      = 1'b0;
      unique case (r_state)
         // The first key_valid in idle already carries bit 0.
         KEY_IDLE, KEY_LOAD: begin
            if (i_key_valid) begin
               w_key_nxt[r_cnt] = i_key_bit;
               if (r_cnt == LAST_IDX) begin
                  w_state_nxt  = KEY_ARMED;
                  w_cnt_nxt    = '0;
                  w_loaded_nxt = 1'b1;
               end else begin
                  w_state_nxt = KEY_LOAD;
                  w_cnt_nxt   = r_cnt + 1'b1;
               end
            end
         end
         KEY_ARMED: begin
`ifdef LOCK_KEY_OTP_EN
            w_state_nxt = KEY_ARMED;
`else
            // The restarting pulse carries no key data; loading begins at bit 0 afterwards.
            if (i_key_valid) begin
               w_state_nxt  = KEY_LOAD;
               w_cnt_nxt    = '0;
               w_key_nxt    = '0;
               w_loaded_nxt = 1'b0;
               o_flush      = 1'b1;
            end
`endif
         end
         default: w_state_nxt = KEY_IDLE;
      endcase
   end

   assign o_key        = r_key;
   assign o_key_loaded = r_loaded;

endmodule

// File: rtl/locked_pipe_adder.sv
// Two-stage valid/ready locked adder: perturb on PROT_PATTERN, restore on the loaded key.
// Optional macro LOCK_KEY_OTP_EN makes the key one-time programmable (see lock_key_loader).
module locked_pipe_adder
   import locked_pkg::*;
#(
   parameter int unsigned     W            = 4,
   parameter logic [2*W-1:0]  PROT_PATTERN = (2*W)'(DEF_PROT_PATTERN),
   parameter logic [W:0]      FLIP_MASK    = (W+1)'(DEF_FLIP_MASK),
   parameter int unsigned     OUT_CH       = 2
) (
   input logic                clk,
   input logic                rst,
   locked_pipe_adder_if.slave bus
);
   localparam int unsigned KW = 2 * W;

   logic [KW-1:0] w_key;
   logic          w_key_loaded;
   logic          w_flush;

   lock_key_loader #(
      .KW (KW)
   ) u_key_loader (
      .clk          (clk),
      .rst          (rst),
      .i_key_bit    (bus.key_bit),
      .i_key_valid  (bus.key_valid),
      .o_key        (w_key),
      .o_key_loaded (w_key_loaded),
      .o_flush      (w_flush)
   );

   logic         r_s1_valid;
   logic [W:0]   r_s1_sum;
   logic         r_s1_pert;
   logic         r_s1_rest;
   logic         r_out_valid;
   logic [W:0]   r_out;

   logic         w_s2_adv;
   logic         w_accept;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;
   logic [W:0]   w_sum;
   logic         w_pert;
   logic         w_rest;
   logic [W:0]   w_res;

   always_comb begin
      // Stage 1 may only move when the output register is free or being drained.
      w_s2_adv = !r_out_valid || bus.out_ready;
      w_accept = bus.in_valid && w_key_loaded && w_s2_adv;
      w_a      = bus.inputs[W-1:0];
      w_b      = bus.inputs[2*W-1:W];
      w_sum    = {1'b0, w_a} + {1'b0, w_b};
      w_pert   = (bus.inputs == PROT_PATTERN);
      w_rest   = (bus.inputs == w_key);
      w_res    = r_s1_sum ^ (FLIP_MASK & {(W+1){r_s1_pert ^ r_s1_rest}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_sum    <= '0;
         r_s1_pert   <= 1'b0;
         r_s1_rest   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_flush) begin
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_s2_adv) begin
         r_s1_valid  <= w_accept;
         r_out_valid <= r_s1_valid;
         if (w_accept) begin
            r_s1_sum  <= w_sum;
            r_s1_pert <= w_pert;
            r_s1_rest <= w_rest;
         end
         if (r_s1_valid) begin
            r_out <= w_res;
         end
      end
   end

   assign bus.key_loaded = w_key_loaded;
   assign bus.in_ready   = w_key_loaded && w_s2_adv;
   assign bus.out_valid  = r_out_valid;
   assign bus.out        = {OUT_CH{r_out}};

endmodule

// File: tb/tb_locked_pipe_adder.sv
// Directed self-checking bench for locked_pipe_adder (W=4, two output channels).
module tb_locked_pipe_adder;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   locked_pipe_adder_if #(.W(4), .OUT_CH(2)) bus ();

   locked_pipe_adder #(
      .W            (4),
      .PROT_PATTERN (8'h01),
      .FLIP_MASK    (5'h01),
      .OUT_CH       (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] bp_in  [6] = '{8'h23, 8'h45, 8'h9A, 8'hFF, 8'h70, 8'h0E};
   logic [4:0] bp_exp [6] = '{5'h05, 5'h09, 5'h13, 5'h1E, 5'h07, 5'h0E};

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] rep(input logic [4:0] v);
      return {v, v};
   endfunction

   function automatic logic [4:0] add_ab(input logic [7:0] x);
      return {1'b0, x[3:0]} + {1'b0, x[7:4]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_bits(input logic [7:0] k, input int n);
      for (int i = 0; i < n; i++) begin
         bus.key_valid = 1'b1;
         bus.key_bit   = k[i];
         tick();
      end
      bus.key_valid = 1'b0;
   endtask

   task automatic send_one(input string tag, input logic [7:0] x, input logic [4:0] exp);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.inputs    = x;
      #1;
      check({tag, "_rdy"}, 16'(bus.in_ready), 16'd1);
      tick();
      bus.in_valid = 1'b0;
      check({tag, "_lat1"}, 16'(bus.out_valid), 16'd0);
      tick();
      check({tag, "_vld"}, 16'(bus.out_valid), 16'd1);
      check(tag, 16'(bus.out), 16'(rep(exp)));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         nxt;
      int         idx;
      int         k;
      logic [7:0] ev;
      logic       exp_loaded;
      logic       exp_ov;
      logic [4:0] exp_prot;
      logic [4:0] exp_key;

      rst           = 1'b1;
      bus.key_bit   = 1'b0;
      bus.key_valid = 1'b0;
      bus.in_valid  = 1'b0;
      bus.inputs    = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_loaded", 16'(bus.key_loaded), 16'd0);
      check("rst_ovalid", 16'(bus.out_valid), 16'd0);
      check("rst_out", 16'(bus.out), 16'd0);
      check("rst_iready", 16'(bus.in_ready), 16'd0);

      // Operands offered before any key are refused.
      bus.in_valid = 1'b1;
      bus.inputs   = 8'h01;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("prekey_rdy", 16'(bus.in_ready), 16'd0);
         check("prekey_ovld", 16'(bus.out_valid), 16'd0);
      end
      bus.in_valid = 1'b0;

      // Reset in the middle of a load, then a full fresh load of key 0x00.
      load_bits(8'hFF, 5);
      check("part_loaded", 16'(bus.key_loaded), 16'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_loaded", 16'(bus.key_loaded), 16'd0);
      load_bits(8'h00, 7);
      check("k0_7bits", 16'(bus.key_loaded), 16'd0);
      load_bits(8'h00, 1);
      check("k0_loaded", 16'(bus.key_loaded), 16'd1);

      send_one("k0_pert", 8'h01, 5'h00);
      send_one("k0_rest", 8'h00, 5'h01);
      send_one("k0_plain", 8'h11, 5'h02);
      send_one("k0_ff", 8'hFF, 5'h1E);

      // Correct key.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      load_bits(8'h01, 8);
      check("k1_loaded", 16'(bus.key_loaded), 16'd1);
      send_one("k1_prot", 8'h01, 5'h01);
      send_one("k1_00", 8'h00, 5'h00);

      // Exhaustive back-to-back stream.
      nxt = 0;
      for (int c = 0; c < 260; c++) begin
         bus.in_valid = (c < 256);
         bus.inputs   = 8'(c);
         #1;
         if (c < 256) check("stream_rdy", 16'(bus.in_ready), 16'd1);
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            ev = 8'(nxt);
            check("stream", 16'(bus.out), 16'(rep(add_ab(ev))));
            nxt++;
         end
         if (c == 256) check("stream_tput", 16'(nxt), 16'd256);
      end
      bus.in_valid = 1'b0;
      check("stream_total", 16'(nxt), 16'd256);

      // Three-cycle output stall mid-stream.
      idx = 0;
      k   = 0;
      for (int c = 0; c < 16; c++) begin
         bus.out_ready = !(c >= 3 && c < 6);
         bus.in_valid  = (idx < 6);
         bus.inputs    = (idx < 6) ? bp_in[idx] : 8'h00;
         #1;
         if (c >= 3 && c < 6) begin
            check("bp_stall_rdy", 16'(bus.in_ready), 16'd0);
            check("bp_stall_vld", 16'(bus.out_valid), 16'd1);
            check("bp_hold", 16'(bus.out), 16'(rep(bp_exp[k])));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (k < 6) check("bp_data", 16'(bus.out), 16'(rep(bp_exp[k])));
            k++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("bp_count", 16'(k), 16'd6);
      check("bp_sent", 16'(idx), 16'd6);

      // Reload attempt with 0xFF while a result is pending.
`ifdef LOCK_KEY_OTP_EN
      exp_loaded = 1'b1;
      exp_ov     = 1'b1;
      exp_prot   = 5'h01;
      exp_key    = 5'h1E;
`else
      exp_loaded = 1'b0;
      exp_ov     = 1'b0;
      exp_prot   = 5'h00;
      exp_key    = 5'h1F;
`endif
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.inputs    = 8'h23;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("rl_pending", 16'(bus.out_valid), 16'd1);
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'b1;
      tick();
      bus.key_valid = 1'b0;
      check("rl_loaded_drop", 16'(bus.key_loaded), 16'(exp_loaded));
      check("rl_flush", 16'(bus.out_valid), 16'(exp_ov));
      bus.out_ready = 1'b1;
      tick();
      tick();
      load_bits(8'hFF, 8);
      check("rl_loaded", 16'(bus.key_loaded), 16'd1);
      send_one("rl_prot", 8'h01, exp_prot);
      send_one("rl_key", 8'hFF, exp_key);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
